// File: rtl/instr_fetch_ctrl_if.sv
// Fetch controller bundle: program-memory port, instruction bus and execution-FSM handshakes.
// master = the fetch controller, slave = memory / execution FSMs / supervisor side.
interface instr_fetch_ctrl_if #(
    parameter int PC_W = 6
);
    logic            run;
    logic [15:0]     memData;
    logic            memRd;
    logic [PC_W-1:0] memAddr;
    logic [15:0]     instruction;
    logic            pcInc;
    logic            done;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            halted;
    logic            fault;

    modport master (
        input  run, memData, pcInc, done,
        output memRd, memAddr, instruction, pc, busy, halted, fault
    );

    modport slave (
        output run, memData, pcInc, done,
        input  memRd, memAddr, instruction, pc, busy, halted, fault
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch/dispatch: owns pc, reads sync program memory, presents each word until done,
// then one bubble word so every execution FSM is back in its initial state.
//
// state   | meaning
// IDLE    | waiting for run, idle word on the bus
// FETCH   | memRd strobe for address pc
// LATCH   | memData captured; halt opcode ends here
// EXEC    | word presented, pcInc honoured, waiting for done or timeout
// BUBBLE  | one idle-word cycle, then fetch again or go idle
// HALTED  | parked until reset; fault tells timeout from halt opcode
module instr_fetch_ctrl #(
    parameter int          PC_W      = 6,
    parameter logic [15:0] IDLE_WORD = 16'hF000,
    parameter logic [3:0]  HALT_OP   = 4'hE,
    parameter int          TIMEOUT   = 15
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_ctrl_if.master bus
);
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_BUBBLE,
        S_HALTED
    } state_t;

    state_t           state;
    logic [PC_W-1:0]  pc_q;
    logic [15:0]      ir_q;
    logic             mem_rd_q;
    logic             busy_q;
    logic             halted_q;
    logic             fault_q;
    logic [CNT_W-1:0] cnt_q;

    // The IR doubles as the instruction bus register; it holds the idle word outside EXEC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= IDLE_WORD;
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.run) begin
                        state    <= S_FETCH;
                        mem_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state    <= S_LATCH;
                    mem_rd_q <= 1'b0;
                end
                S_LATCH: begin
                    if (bus.memData[15:12] == HALT_OP) begin
                        state    <= S_HALTED;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                        ir_q  <= bus.memData;
                        cnt_q <= '0;
                    end
                end
                S_EXEC: begin
                    if (bus.pcInc) begin
                        pc_q <= pc_q + PC_W'(1);
                    end
                    if (bus.done) begin
                        state <= S_BUBBLE;
                        ir_q  <= IDLE_WORD;
                    end else if (cnt_q == CNT_LAST) begin
                        state    <= S_HALTED;
                        ir_q     <= IDLE_WORD;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        fault_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_BUBBLE: begin
                    if (bus.run) begin
                        state    <= S_FETCH;
                        mem_rd_q <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.memRd       = mem_rd_q;
    assign bus.memAddr     = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instruction = ir_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
endmodule
